// File: rtl/ro_pair_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ro_pair_counter: RO-PUF measurement stage (enable, count, compare)       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ro_pair_counter #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int WINDOW_CYCLES = 4096
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             RO_A,
  input  logic             RO_B,
  output logic             RO_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             RESP,
  output logic             TIE,
  output logic             SAT,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
);

  localparam int TMAX  = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               a_meta_q, a_meta_d, a_sync_q, a_sync_d, a_hist_q, a_hist_d;
  logic               b_meta_q, b_meta_d, b_sync_q, b_sync_d, b_hist_q, b_hist_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]   cnt_a_out_q, cnt_a_out_d, cnt_b_out_q, cnt_b_out_d;
  logic               ro_en_q, ro_en_d, busy_q, busy_d, done_q, done_d;
  logic               resp_q, resp_d, tie_q, tie_d, sat_q, sat_d;
  logic               edge_a, edge_b;

  always_comb begin
    a_meta_d    = RO_A;
    a_sync_d    = a_meta_q;
    a_hist_d    = a_sync_q;
    b_meta_d    = RO_B;
    b_sync_d    = b_meta_q;
    b_hist_d    = b_sync_q;
    edge_a      = a_sync_q & ~a_hist_q;
    edge_b      = b_sync_q & ~b_hist_q;
    state_d     = state_q;
    tmr_d       = tmr_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    cnt_a_out_d = cnt_a_out_q;
    cnt_b_out_d = cnt_b_out_q;
    resp_d      = resp_q;
    tie_d       = tie_q;
    sat_d       = sat_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SETTLE;
          tmr_d   = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = COUNT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      COUNT: begin
        if (edge_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (edge_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
        if (tmr_q == WINDOW_LAST) begin
          state_d = REPORT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      REPORT: begin
        // Results become visible together with DONE, one cycle after REPORT.
        state_d     = IDLE;
        done_d      = 1'b1;
        cnt_a_out_d = cnt_a_q;
        cnt_b_out_d = cnt_b_q;
        resp_d      = cnt_a_q > cnt_b_q;
        tie_d       = cnt_a_q == cnt_b_q;
        sat_d       = (cnt_a_q == CNT_MAX) || (cnt_b_q == CNT_MAX);
      end
      default: state_d = IDLE;
    endcase

    ro_en_d = (state_d == SETTLE) || (state_d == COUNT);
    busy_d  = ro_en_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      a_meta_q    <= 1'b0;
      a_sync_q    <= 1'b0;
      a_hist_q    <= 1'b0;
      b_meta_q    <= 1'b0;
      b_sync_q    <= 1'b0;
      b_hist_q    <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      cnt_a_out_q <= '0;
      cnt_b_out_q <= '0;
      ro_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= 1'b0;
      tie_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      a_meta_q    <= a_meta_d;
      a_sync_q    <= a_sync_d;
      a_hist_q    <= a_hist_d;
      b_meta_q    <= b_meta_d;
      b_sync_q    <= b_sync_d;
      b_hist_q    <= b_hist_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      cnt_a_out_q <= cnt_a_out_d;
      cnt_b_out_q <= cnt_b_out_d;
      ro_en_q     <= ro_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      tie_q       <= tie_d;
      sat_q       <= sat_d;
    end
  end

  assign RO_EN = ro_en_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign RESP  = resp_q;
  assign TIE   = tie_q;
  assign SAT   = sat_q;
  assign CNT_A = cnt_a_out_q;
  assign CNT_B = cnt_b_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_pair_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ro_pair_counter: scoreboard bench for ro_pair_counter                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ro_pair_counter;

  typedef struct {
    int     lo_a, hi_a, lo_b, hi_b;
    logic   resp, tie, sat, eq;
    longint t_k;
  } exp_t;

  // START sampled at edge t_k -> DONE seen at the negedge after edge k+S+W+1.
  localparam longint LAT = (4 + 120 + 1) * 10 + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_m = 1'b0, start_s = 1'b0;
  logic ro [4] = '{default: 1'b0};
  int   half [4] = '{default: 0};

  logic ro_en_m, busy_m, done_m, resp_m, tie_m, sat_m;
  logic [15:0] cnt_a_m, cnt_b_m;
  logic ro_en_s, busy_s, done_s, resp_s, tie_s, sat_s;
  logic [3:0] cnt_a_s, cnt_b_s;

  exp_t q_m[$];
  exp_t q_s[$];
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ro_pair_counter #(.CNT_W(16), .SETTLE_CYCLES(4), .WINDOW_CYCLES(120)) u_main (
    .CLK(clk), .RST_N(rst_n), .START(start_m), .RO_A(ro[0]), .RO_B(ro[1]),
    .RO_EN(ro_en_m), .BUSY(busy_m), .DONE(done_m), .RESP(resp_m), .TIE(tie_m),
    .SAT(sat_m), .CNT_A(cnt_a_m), .CNT_B(cnt_b_m)
  );

  ro_pair_counter #(.CNT_W(4), .SETTLE_CYCLES(4), .WINDOW_CYCLES(120)) u_sat (
    .CLK(clk), .RST_N(rst_n), .START(start_s), .RO_A(ro[2]), .RO_B(ro[3]),
    .RO_EN(ro_en_s), .BUSY(busy_s), .DONE(done_s), .RESP(resp_s), .TIE(tie_s),
    .SAT(sat_s), .CNT_A(cnt_a_s), .CNT_B(cnt_b_s)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_tot++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic logic en_of(input int i);
    return (i < 2) ? ro_en_m : ro_en_s;
  endfunction

  // Oscillator models: start low when enabled, toggle every half[i] cycles.
  initial begin
    int ph [4] = '{default: 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!en_of(i) || half[i] == 0) begin
          ro[i] = 1'b0;
          ph[i] = 0;
        end else begin
          ph[i]++;
          if (ph[i] == half[i]) begin
            ro[i] = ~ro[i];
            ph[i] = 0;
          end
        end
      end
    end
  end

  // Monitor: pops an expectation whenever either DUT pulses DONE.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done_m) begin
          if (q_m.size() == 0) check("unexp_done_m", done_m, 0);
          else begin
            e = q_m.pop_front();
            check_rng("cnt_a_m", cnt_a_m, e.lo_a, e.hi_a);
            check_rng("cnt_b_m", cnt_b_m, e.lo_b, e.hi_b);
            check("resp_m", resp_m, e.resp);
            check("tie_m", tie_m, e.tie);
            check("sat_m", sat_m, e.sat);
            if (e.eq) check("cnt_eq_m", cnt_a_m, cnt_b_m);
            check("latency_m", $time - e.t_k, LAT);
            check("busy_at_done_m", busy_m, 0);
            check("ro_en_at_done_m", ro_en_m, 0);
          end
        end
        if (done_s) begin
          if (q_s.size() == 0) check("unexp_done_s", done_s, 0);
          else begin
            e = q_s.pop_front();
            check_rng("cnt_a_s", cnt_a_s, e.lo_a, e.hi_a);
            check_rng("cnt_b_s", cnt_b_s, e.lo_b, e.hi_b);
            check("resp_s", resp_s, e.resp);
            check("tie_s", tie_s, e.tie);
            check("sat_s", sat_s, e.sat);
            if (e.eq) check("cnt_eq_s", cnt_a_s, cnt_b_s);
            check("latency_s", $time - e.t_k, LAT);
            check("busy_at_done_s", busy_s, 0);
            check("ro_en_at_done_s", ro_en_s, 0);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int la, ha, lb, hb, input logic rs, ti, sa, eq, input longint tk);
    exp_t e;
    e.lo_a = la; e.hi_a = ha; e.lo_b = lb; e.hi_b = hb;
    e.resp = rs; e.tie = ti; e.sat = sa; e.eq = eq; e.t_k = tk;
    return e;
  endfunction

  task automatic wait_drain();
    int n = 0;
    while ((q_m.size() != 0 || q_s.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q_m.size() + q_s.size(), 0);
  endtask

  task automatic run_m(input int la, ha, lb, hb, input logic rs, ti, sa, eq);
    @(negedge clk) start_m = 1'b1;
    @(posedge clk) q_m.push_back(mk(la, ha, lb, hb, rs, ti, sa, eq, $time));
    @(negedge clk) start_m = 1'b0;
    wait_drain();
  endtask

  task automatic run_s(input int la, ha, lb, hb, input logic rs, ti, sa, eq);
    @(negedge clk) start_s = 1'b1;
    @(posedge clk) q_s.push_back(mk(la, ha, lb, hb, rs, ti, sa, eq, $time));
    @(negedge clk) start_s = 1'b0;
    wait_drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ro_en"}, ro_en_m, 0);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_done"}, done_m, 0);
    check({tag, "_cnt_a"}, cnt_a_m, 0);
    check({tag, "_cnt_b"}, cnt_b_m, 0);
    check({tag, "_resp"}, resp_m, 0);
    check({tag, "_tie"}, tie_m, 0);
    check({tag, "_sat"}, sat_m, 0);
  endtask

  initial begin
    longint tk;
    int dones, low_len;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A period 6 (20 edges), B period 8 (15 edges) over 120 cycles.
    half[0] = 3; half[1] = 4;
    run_m(19, 21, 14, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    half[0] = 4; half[1] = 3;
    run_m(14, 16, 19, 21, 1'b0, 1'b0, 1'b0, 1'b0);
    half[0] = 4; half[1] = 4;
    run_m(14, 16, 14, 16, 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-COUNT; the aborted run owes no DONE.
    half[0] = 3; half[1] = 4;
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (200) @(negedge clk);

    // Extra START pulses during SETTLE and COUNT must be ignored.
    @(negedge clk) start_m = 1'b1;
    @(posedge clk) q_m.push_back(mk(19, 21, 14, 16, 1'b1, 1'b0, 1'b0, 1'b0, $time));
    @(negedge clk) start_m = 1'b0;
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
    repeat (60) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
    wait_drain();
    repeat (150) @(negedge clk);

    // Held START: back-to-back runs every 126 cycles, BUSY low for 2.
    @(negedge clk) start_m = 1'b1;
    @(posedge clk) tk = $time;
    for (int n = 0; n < 3; n++)
      q_m.push_back(mk(19, 21, 14, 16, 1'b1, 1'b0, 1'b0, 1'b0, tk + n * 1260));
    dones = 0;
    low_len = 0;
    for (int c = 0; c < 420 && dones < 3; c++) begin
      @(negedge clk);
      if (busy_m) begin
        if (low_len > 0) check("busy_gap", low_len, 2);
        low_len = 0;
      end else if (dones > 0) begin
        low_len++;
      end
      if (done_m) dones++;
    end
    start_m = 1'b0;
    check("held_done_count", dones, 3);
    wait_drain();

    // Idle oscillators.
    half[0] = 0; half[1] = 0;
    run_m(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // 4-bit counters: 30 edges saturate at 15.
    half[2] = 2; half[3] = 0;
    run_s(15, 15, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    half[3] = 2;
    run_s(15, 15, 15, 15, 1'b0, 1'b1, 1'b1, 1'b1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
